regfile_sb: RTL and testbench



---
 rtl/regfile_sb_pkg.sv | 21 ++
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_sb_rd_port.sv | 46 ++++
 rtl/regfile_sb.sv | 131 +++++++++++++
 tb/tb_regfile_sb.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: FSM state encoding,
// default geometry and the hardwired-zero register address.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    // Sweep controller states
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_e;

    // Default geometry of the register file
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NR_REGS    = 32;
    localparam int DEF_NR_RD      = 2;

    // Register that always reads zero and never becomes busy
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback and the register file: write port, issue
// marking, clear request, packed read ports and the ready flag.
// Optional feature macro: REGFILE_BYPASS_EN (no effect on this interface).
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NR_RD      = DEF_NR_RD
);
    logic                        wen;
    logic [ADDR_WIDTH-1:0]       addrw;
    logic [WIDTH-1:0]            dinw;
    logic                        iss_en;
    logic [ADDR_WIDTH-1:0]       iss_addr;
    logic                        clr;
    logic [NR_RD*ADDR_WIDTH-1:0] addr_rd;
    logic [NR_RD*WIDTH-1:0]      dout_rd;
    logic [NR_RD-1:0]            busy_rd;
    logic                        ready;

    // Pipeline side (decode / writeback) drives requests
    modport master (
        output wen, addrw, dinw, iss_en, iss_addr, clr, addr_rd,
        input  dout_rd, busy_rd, ready
    );

    // Register file side
    modport slave (
        input  wen, addrw, dinw, iss_en, iss_addr, clr, addr_rd,
        output dout_rd, busy_rd, ready
    );
endinterface

// File: rtl/regfile_sb_rd_port.sv
// One combinational read port: address decode, zero for register 0 and for
// addresses beyond the file, and optional write-to-read forwarding.
// Optional feature macro: REGFILE_BYPASS_EN.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NR_REGS    = DEF_NR_REGS
) (
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [NR_REGS*WIDTH-1:0] regs_i,
    input  logic [NR_REGS-1:0]       busy_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                     wr_en_i,
    input  logic [ADDR_WIDTH-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_WIDTH-1:0]    iss_addr_i,
`endif
    output logic [WIDTH-1:0]         dout_o,
    output logic                     busy_o
);
    // One extra bit so NR_REGS == 2**ADDR_WIDTH still fits
    localparam logic [ADDR_WIDTH:0] NR_REGS_W = (ADDR_WIDTH+1)'(NR_REGS);

    logic                  in_range;
    logic [ADDR_WIDTH-1:0] sel;

    // Decode the address and select stored data/busy, forwarding a committing write
    always_comb begin
        in_range = (addr_i != ADDR_WIDTH'(ZERO_REG)) && ({1'b0, addr_i} < NR_REGS_W);
        // Park the select on register 0 when out of range so the slice never overruns
        sel      = in_range ? addr_i : ADDR_WIDTH'(ZERO_REG);
        dout_o   = in_range ? regs_i[int'(sel)*WIDTH +: WIDTH] : '0;
        busy_o   = in_range & busy_i[sel];
`ifdef REGFILE_BYPASS_EN
        // wr_en_i is only high for an in-range, nonzero write that commits this cycle;
        // the write retires the pending writer unless a new issue lands on it too
        if (wr_en_i && (wr_addr_i == addr_i)) begin
            dout_o = wr_data_i;
            busy_o = iss_en_i && (iss_addr_i == addr_i);
        end
`endif
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with hardwired-zero r0, per-register busy scoreboard and a
// soft-clear sweep that zeroes r1..NR_REGS-1 one register per cycle.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write forwarding on reads).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int               NR_REGS    = DEF_NR_REGS,
    parameter int               NR_RD      = DEF_NR_RD,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0]   NR_REGS_W = (ADDR_WIDTH+1)'(NR_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NR_REGS-1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [WIDTH-1:0]         regs_q [NR_REGS];
    logic [NR_REGS-1:0]       busy_q, busy_d;
    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    cnt_q, cnt_d;

    logic                     idle;
    logic                     wr_ok, iss_ok;
    logic [NR_REGS*WIDTH-1:0] regs_flat;
    logic [NR_RD*WIDTH-1:0]   dout_flat;
    logic [NR_RD-1:0]         busy_flat;

    // Writes and issues only commit when idle and not superseded by a clear request
    always_comb begin
        idle   = (state_q == S_IDLE);
        wr_ok  = idle && !bus.clr && bus.wen &&
                 (bus.addrw != ZERO_ADDR) && ({1'b0, bus.addrw} < NR_REGS_W);
        iss_ok = idle && !bus.clr && bus.iss_en &&
                 (bus.iss_addr != ZERO_ADDR) && ({1'b0, bus.iss_addr} < NR_REGS_W);
    end

    // Next state for the sweep FSM, its counter and the scoreboard
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clr) begin
                    state_d = S_SWEEP;
                    cnt_d   = ADDR_WIDTH'(1);
                end else begin
                    // Issue is applied after the write so a newer pending writer keeps the bit set
                    if (wr_ok)  busy_d[bus.addrw]    = 1'b0;
                    if (iss_ok) busy_d[bus.iss_addr] = 1'b1;
                end
            end
            S_SWEEP: begin
                busy_d[cnt_q] = 1'b0;
                if (cnt_q == LAST_REG) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Register storage: reset load, sweep zeroing or the committed write
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= (i == ZERO_REG) ? '0 : RESET_VAL;
            end
        end else if (state_q == S_SWEEP) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            regs_q[bus.addrw] <= bus.dinw;
        end
    end

    genvar gi;

    // Flatten storage so every read port sees the whole file
    generate
        for (gi = 0; gi < NR_REGS; gi++) begin : g_flat
            assign regs_flat[gi*WIDTH +: WIDTH] = regs_q[gi];
        end
    endgenerate

    generate
        for (gi = 0; gi < NR_RD; gi++) begin : g_rd
            regfile_rd_port #(
                .WIDTH      (WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .NR_REGS    (NR_REGS)
            ) u_rd (
                .addr_i     (bus.addr_rd[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .regs_i     (regs_flat),
                .busy_i     (busy_q),
`ifdef REGFILE_BYPASS_EN
                .wr_en_i    (wr_ok),
                .wr_addr_i  (bus.addrw),
                .wr_data_i  (bus.dinw),
                .iss_en_i   (iss_ok),
                .iss_addr_i (bus.iss_addr),
`endif
                .dout_o     (dout_flat[gi*WIDTH +: WIDTH]),
                .busy_o     (busy_flat[gi])
            );
        end
    endgenerate

    assign bus.dout_rd = dout_flat;
    assign bus.busy_rd = busy_flat;
    assign bus.ready   = idle;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset values, write/read, scoreboard,
// clear sweep, reset during a sweep and out-of-range accesses.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.WIDTH(32), .ADDR_WIDTH(5), .NR_RD(2)) bus0 ();
    regfile_sb_if #(.WIDTH(32), .ADDR_WIDTH(5), .NR_RD(1)) bus1 ();

    regfile_sb #(
        .WIDTH(32), .ADDR_WIDTH(5), .NR_REGS(32), .NR_RD(2), .RESET_VAL(32'h5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    regfile_sb #(
        .WIDTH(32), .ADDR_WIDTH(5), .NR_REGS(24), .NR_RD(1), .RESET_VAL(32'h0)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.wen    = 1'b0;
        bus0.iss_en = 1'b0;
        bus0.clr    = 1'b0;
    endtask

    task automatic rd0(input logic [4:0] a0, input logic [4:0] a1);
        bus0.addr_rd = {a1, a0};
        #1;
    endtask

    initial begin
        bus0.wen = 0; bus0.addrw = '0; bus0.dinw = '0; bus0.iss_en = 0;
        bus0.iss_addr = '0; bus0.clr = 0; bus0.addr_rd = '0;
        bus1.wen = 0; bus1.addrw = '0; bus1.dinw = '0; bus1.iss_en = 0;
        bus1.iss_addr = '0; bus1.clr = 0; bus1.addr_rd = '0;

        // Reset for one edge
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd0(5'd3, 5'd31);
        check("rst_r3", bus0.dout_rd[31:0], 32'h5);
        check("rst_r31", bus0.dout_rd[63:32], 32'h5);
        check("rst_busy", {30'd0, bus0.busy_rd}, 32'h0);
        check("rst_ready", {31'd0, bus0.ready}, 32'h1);
        rd0(5'd0, 5'd3);
        check("rst_r0", bus0.dout_rd[31:0], 32'h0);

        // Write r7, read on port 1 same cycle and next cycle
        bus0.wen = 1; bus0.addrw = 5'd7; bus0.dinw = 32'hDEADBEEF;
        rd0(5'd0, 5'd7);
        check("wr_same_cycle", bus0.dout_rd[63:32], BYP ? 32'hDEADBEEF : 32'h5);
        tick();
        idle0();
        rd0(5'd0, 5'd7);
        check("wr_next_cycle", bus0.dout_rd[63:32], 32'hDEADBEEF);

        // Scoreboard: issue r9
        bus0.iss_en = 1; bus0.iss_addr = 5'd9;
        tick();
        idle0();
        rd0(5'd9, 5'd0);
        check("iss_busy", {31'd0, bus0.busy_rd[0]}, 32'h1);
        // Issue again to busy r9 together with its write
        bus0.iss_en = 1; bus0.iss_addr = 5'd9;
        bus0.wen = 1; bus0.addrw = 5'd9; bus0.dinw = 32'h1234;
        rd0(5'd9, 5'd0);
        check("iss_wr_same_busy", {31'd0, bus0.busy_rd[0]}, 32'h1);
        check("iss_wr_same_data", bus0.dout_rd[31:0], BYP ? 32'h1234 : 32'h5);
        tick();
        idle0();
        rd0(5'd9, 5'd0);
        check("iss_wr_busy_kept", {31'd0, bus0.busy_rd[0]}, 32'h1);
        check("iss_wr_data", bus0.dout_rd[31:0], 32'h1234);
        // Writeback alone retires r9
        bus0.wen = 1; bus0.addrw = 5'd9; bus0.dinw = 32'h5678;
        rd0(5'd9, 5'd0);
        check("wb_same_busy", {31'd0, bus0.busy_rd[0]}, BYP ? 32'h0 : 32'h1);
        tick();
        idle0();
        rd0(5'd9, 5'd0);
        check("wb_busy_clr", {31'd0, bus0.busy_rd[0]}, 32'h0);
        check("wb_data", bus0.dout_rd[31:0], 32'h5678);
        // Issue and write to r0 are ignored
        bus0.iss_en = 1; bus0.iss_addr = 5'd0;
        bus0.wen = 1; bus0.addrw = 5'd0; bus0.dinw = 32'hFFFF;
        tick();
        idle0();
        rd0(5'd0, 5'd0);
        check("r0_busy", {30'd0, bus0.busy_rd}, 32'h0);
        check("r0_data", bus0.dout_rd[31:0], 32'h0);

        // Preload r1..r31 and mark r20 busy
        for (int i = 1; i < 32; i++) begin
            bus0.wen = 1; bus0.addrw = 5'(i); bus0.dinw = 32'h100 + 32'(i);
            tick();
        end
        idle0();
        bus0.iss_en = 1; bus0.iss_addr = 5'd20;
        tick();
        // Clear request beats a simultaneous write and issue to r4
        bus0.iss_en = 1; bus0.iss_addr = 5'd4;
        bus0.wen = 1; bus0.addrw = 5'd4; bus0.dinw = 32'hAAAA;
        bus0.clr = 1;
        tick();
        // During the sweep these must all be ignored
        bus0.clr = 0;
        bus0.wen = 1; bus0.addrw = 5'd31; bus0.dinw = 32'hBAD;
        bus0.iss_en = 1; bus0.iss_addr = 5'd30;
        rd0(5'd4, 5'd20);
        check("clr_drops_write", bus0.dout_rd[31:0], 32'h104);
        check("clr_drops_issue", {31'd0, bus0.busy_rd[0]}, 32'h0);
        check("r20_busy_pre_sweep", {31'd0, bus0.busy_rd[1]}, 32'h1);
        for (int k = 1; k < 32; k++) begin
            bus0.clr = (k == 15);
            rd0(5'(k), 5'd31);
            check($sformatf("sweep_ready_low_%0d", k), {31'd0, bus0.ready}, 32'h0);
            check($sformatf("pre_sweep_r%0d", k), bus0.dout_rd[31:0], 32'h100 + 32'(k));
            tick();
            rd0(5'(k), 5'd31);
            check($sformatf("swept_r%0d", k), bus0.dout_rd[31:0], 32'h0);
        end
        idle0();
        rd0(5'd31, 5'd20);
        check("sweep_done_ready", {31'd0, bus0.ready}, 32'h1);
        check("sweep_r31", bus0.dout_rd[31:0], 32'h0);
        check("sweep_r20_busy", {31'd0, bus0.busy_rd[1]}, 32'h0);
        rd0(5'd30, 5'd4);
        check("sweep_iss_ignored", {31'd0, bus0.busy_rd[0]}, 32'h0);
        check("sweep_r4", bus0.dout_rd[63:32], 32'h0);

        // Reset in the middle of a sweep
        bus0.wen = 1; bus0.addrw = 5'd5; bus0.dinw = 32'h77;
        tick();
        idle0();
        bus0.iss_en = 1; bus0.iss_addr = 5'd6;
        tick();
        idle0();
        bus0.clr = 1;
        tick();
        idle0();
        repeat (9) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd0(5'd5, 5'd6);
        check("midrst_ready", {31'd0, bus0.ready}, 32'h1);
        check("midrst_r5", bus0.dout_rd[31:0], 32'h5);
        check("midrst_r6_busy", {31'd0, bus0.busy_rd[1]}, 32'h0);
        rd0(5'd1, 5'd31);
        check("midrst_r1", bus0.dout_rd[31:0], 32'h5);
        check("midrst_r31", bus0.dout_rd[63:32], 32'h5);

        // Out of range on the 24-register instance
        bus1.wen = 1; bus1.addrw = 5'd28; bus1.dinw = 32'hCAFE;
        bus1.iss_en = 1; bus1.iss_addr = 5'd28;
        tick();
        bus1.wen = 1; bus1.addrw = 5'd23; bus1.dinw = 32'h1111;
        bus1.iss_en = 1; bus1.iss_addr = 5'd23;
        tick();
        bus1.wen = 0; bus1.iss_en = 0;
        bus1.addr_rd = 5'd28;
        #1;
        check("oor_r28_data", bus1.dout_rd, 32'h0);
        check("oor_r28_busy", {31'd0, bus1.busy_rd}, 32'h0);
        bus1.addr_rd = 5'd23;
        #1;
        check("last_r23_data", bus1.dout_rd, 32'h1111);
        check("last_r23_busy", {31'd0, bus1.busy_rd}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
